mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shared single-port memory arbiter for the fetch and memory stages.
// Data wins contention unless fetch has waited STARVE_LIMIT data grants.
module mem_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ack,
   output logic [31:0] if_rdata,
   input  logic        m_req,
   input  logic        m_we,
   input  logic [31:0] m_addr,
   input  logic [31:0] m_wdata,
   input  logic [3:0]  m_be,
   output logic        m_ack,
   output logic [31:0] m_rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ready,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nx;
   logic [3:0]  streak;
   logic        own_d;
   logic        lat_we;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;
   logic [3:0]  lat_be;
   logic        starve;
   logic        grant_d;
   logic        grant_f;
   logic        grant;

   assign starve  = (streak == 4'(STARVE_LIMIT));
   assign grant_d = m_req & ~(if_req & starve);
   assign grant_f = if_req & ~grant_d;
   assign grant   = (state == IDLE) & (grant_d | grant_f);

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state: grant in IDLE, wait for accept, wait for completion.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (grant_d | grant_f) state_nx = ISSUE;
         ISSUE:   if (mem_ready)         state_nx = WAIT;
         WAIT:    if (mem_rvalid)        state_nx = IDLE;
         default:                        state_nx = IDLE;
      endcase
   end

   // Latch the winner's command and update the data streak at grant time.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         own_d     <= 1'b0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_be    <= '0;
         streak    <= '0;
      end else if (grant) begin
         own_d <= grant_d;
         if (grant_d) begin
            lat_we    <= m_we;
            lat_addr  <= m_addr;
            lat_wdata <= m_wdata;
            lat_be    <= m_be;
            if (!if_req) begin
               streak <= '0;
            end else if (streak != 4'hF) begin
               streak <= streak + 4'd1;
            end
         end else begin
            lat_we    <= 1'b0;
            lat_addr  <= if_addr;
            lat_wdata <= '0;
            lat_be    <= 4'hF;
            streak    <= '0;
         end
      end
   end

   // Outputs: command only in ISSUE, ack and read data only on completion.
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_be    = '0;
      if_ack    = 1'b0;
      if_rdata  = '0;
      m_ack     = 1'b0;
      m_rdata   = '0;
      busy      = (state != IDLE);
      if (state == ISSUE) begin
         mem_req   = 1'b1;
         mem_we    = lat_we;
         mem_addr  = lat_addr;
         mem_wdata = lat_wdata;
         mem_be    = lat_be;
      end
      if (state == WAIT && mem_rvalid) begin
         if (own_d) begin
            m_ack   = 1'b1;
            m_rdata = mem_rdata;
         end else begin
            if_ack   = 1'b1;
            if_rdata = mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, memory model and ack scoreboard.
// Hand sequences cover contention, starvation reset, spurious rvalid, reset.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ack;
   logic [31:0] if_rdata;
   logic        m_req;
   logic        m_we;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [3:0]  m_be;
   logic        m_ack;
   logic [31:0] m_rdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ready;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        busy;

   mem_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_ack    (if_ack),
      .if_rdata  (if_rdata),
      .m_req     (m_req),
      .m_we      (m_we),
      .m_addr    (m_addr),
      .m_wdata   (m_wdata),
      .m_be      (m_be),
      .m_ack     (m_ack),
      .m_rdata   (m_rdata),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_be    (mem_be),
      .mem_ready (mem_ready),
      .mem_rvalid(mem_rvalid),
      .mem_rdata (mem_rdata),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_d;
      logic [31:0] rdata;
   } exp_t;

   typedef struct {
      bit          is_d;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      int          stall;
      logic        exp_we;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[5];
   int   total      = 0;
   int   bad        = 0;
   int   acks_seen  = 0;
   int   stall_left = 0;
   bit   hold_rv    = 1'b0;
   bit   force_rv   = 1'b0;

   function automatic logic [31:0] mdata(logic [31:0] a);
      if (a == 32'h40) return 32'h0010_0073;
      return {a[15:0], ~a[15:0]};
   endfunction

   function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Memory model: stalls ready, answers one cycle after accept.
   initial begin
      bit          acc;
      logic [31:0] a;
      mem_ready  = 1'b1;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      forever begin
         @(negedge clk);
         acc = mem_req && mem_ready;
         a   = mem_addr;
         if (mem_req && !mem_ready && stall_left > 0) stall_left--;
         @(posedge clk);
         #2;
         mem_rvalid = (acc && !hold_rv) || force_rv;
         mem_rdata  = force_rv ? 32'hBAD0_0001 : (acc ? mdata(a) : 32'h0);
         mem_ready  = (stall_left == 0);
      end
   end

   // Ack monitor: exclusivity, zero rdata when idle, scoreboard pop.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            chk("ack_excl", {127'b0, if_ack & m_ack}, 0);
            if (!if_ack) chk("if_rdata_zero", {96'b0, if_rdata}, 0);
            if (!m_ack) chk("m_rdata_zero", {96'b0, m_rdata}, 0);
            if (if_ack || m_ack) begin
               if (sb.size() == 0) begin
                  chk("unexpected_ack", {126'b0, if_ack, m_ack}, 0);
               end else begin
                  e = sb.pop_front();
                  chk("ack_owner", {127'b0, m_ack}, {127'b0, e.is_d});
                  chk("ack_rdata", {96'b0, m_ack ? m_rdata : if_rdata},
                      {96'b0, e.rdata});
               end
               acks_seen++;
            end
         end
      end
   end

   task automatic run_single(vec_t v, string nm);
      int n    = 0;
      int reqc = 0;
      bit done = 1'b0;
      if (v.is_d) begin
         m_req = 1'b1;
         if_addr = ~v.addr;
         m_addr  = v.addr;
      end else begin
         if_req = 1'b1;
         if_addr = v.addr;
         m_addr  = ~v.addr;
      end
      m_we    = v.we;
      m_wdata = v.wdata;
      m_be    = v.be;
      stall_left = v.stall;
      sb.push_back('{v.is_d, mdata(v.addr)});
      while (!done && n <= 30) begin
         @(negedge clk);
         if (mem_req) begin
            reqc++;
            chk({nm, "_cmd"}, {59'b0, mem_we, mem_addr, mem_wdata, mem_be},
                {59'b0, v.exp_we, v.addr, v.exp_wdata, v.exp_be});
         end
         if (if_ack || m_ack) done = 1'b1;
         else n++;
      end
      chk({nm, "_done"}, {127'b0, done}, 1);
      chk({nm, "_latency"}, n, 2 + v.stall);
      chk({nm, "_req_cycles"}, reqc, v.stall + 1);
      tick();
      if_req = 1'b0;
      m_req  = 1'b0;
   endtask

   task automatic contend(int n_acks, string nm);
      int start = acks_seen;
      int cyc   = 0;
      if_req  = 1'b1;
      m_req   = 1'b1;
      if_addr = 32'h80;
      m_addr  = 32'h300;
      m_we    = 1'b0;
      m_wdata = '0;
      m_be    = 4'hF;
      while (acks_seen - start < n_acks && cyc < 200) begin
         @(negedge clk);
         #1;
         cyc++;
      end
      chk({nm, "_acks"}, acks_seen - start, n_acks);
      tick();
      if_req = 1'b0;
      m_req  = 1'b0;
   endtask

   task automatic push_order(string ord);
      for (int i = 0; i < ord.len(); i++) begin
         if (ord[i] == "D") sb.push_back('{1'b1, mdata(32'h300)});
         else sb.push_back('{1'b0, mdata(32'h80)});
      end
   endtask

   initial begin
      int cyc;
      vecs[0] = '{0, 1'b1, 32'h40, 32'hCAFE0000, 4'h3, 0, 1'b0, 4'hF, 32'h0};
      vecs[1] = '{1, 1'b0, 32'h200, 32'h11112222, 4'hF, 0,
                  1'b0, 4'hF, 32'h11112222};
      vecs[2] = '{1, 1'b1, 32'h100, 32'hDEADBEEF, 4'b0011, 3,
                  1'b1, 4'b0011, 32'hDEADBEEF};
      vecs[3] = '{0, 1'b1, 32'h1000, 32'h12345678, 4'h5, 2,
                  1'b0, 4'hF, 32'h0};
      vecs[4] = '{1, 1'b1, 32'hFFFFFFFC, 32'h0, 4'h8, 1,
                  1'b1, 4'h8, 32'h0};

      rst     = 1'b0;
      if_req  = 1'b1;
      if_addr = 32'h44;
      m_req   = 1'b1;
      m_we    = 1'b1;
      m_addr  = 32'h88;
      m_wdata = 32'hFFFF_FFFF;
      m_be    = 4'hF;
      @(negedge clk);
      @(negedge clk);
      chk("reset_outputs",
          {if_ack, if_rdata, m_ack, m_rdata, mem_req, mem_we, mem_addr,
           mem_wdata, mem_be, busy}, 0);
      tick();
      if_req = 1'b0;
      m_req  = 1'b0;
      tick();
      rst = 1'b1;

      for (int i = 0; i < 5; i++) begin
         run_single(vecs[i], $sformatf("vec%0d", i));
      end

      tick();
      force_rv = 1'b1;
      @(negedge clk);
      chk("spurious_rv", {125'b0, if_ack, m_ack, busy}, 0);
      tick();
      force_rv = 1'b0;
      @(negedge clk);
      chk("spurious_idle", {127'b0, busy}, 0);

      push_order("DDDDFDDDDF");
      contend(10, "contend10");

      push_order("DD");
      contend(2, "contend2");
      run_single(vecs[1], "solo_data");
      push_order("DDDDF");
      contend(5, "contend5");

      hold_rv = 1'b1;
      m_req   = 1'b1;
      m_we    = 1'b0;
      m_addr  = 32'h500;
      m_be    = 4'hF;
      stall_left = 0;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!(busy && !mem_req) && cyc < 10);
      chk("rst_reach_wait", {126'b0, busy, mem_req}, 2'b10);
      tick();
      rst     = 1'b0;
      m_req   = 1'b0;
      hold_rv = 1'b0;
      @(negedge clk);
      chk("rst_mid_op", {124'b0, busy, mem_req, if_ack, m_ack}, 0);
      tick();
      rst = 1'b1;
      tick();
      force_rv = 1'b1;
      @(negedge clk);
      chk("rst_rv_drop", {125'b0, if_ack, m_ack, busy}, 0);
      tick();
      force_rv = 1'b0;
      run_single(vecs[1], "post_rst");

      tick();
      tick();
      chk("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
